mpsoc_msp430_bb_ext_memory_responder: RTL

//   Responder (target) end of the blackbone external-memory port, driven by the MPSoC-MSP430 system.

---
 rtl/mpsoc_msp430_bb_ext_memory_responder.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mpsoc_msp430_bb_ext_memory_responder.sv
// Responder end of the blackbone external-memory port: word-addressed RAM with byte enables.
// Latency: read data and valid appear READ_LATENCY-1 edges after the request edge; writes take effect at the request edge.
// Backpressure: none, one request per cycle always accepted once init is done; requests during init are dropped and counted.
module mpsoc_msp430_bb_ext_memory_responder #(
  parameter int                    ADDR_WIDTH   = 14,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    READ_LATENCY = 2,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   bb_ext_addr_i,
  input  logic [DATA_WIDTH-1:0]   bb_ext_din_i,
  input  logic                    bb_ext_en_i,
  input  logic [DATA_WIDTH/8-1:0] bb_ext_we_i,
  output logic [DATA_WIDTH-1:0]   bb_ext_dout_o,
  output logic                    bb_ext_valid_o,
  output logic                    init_done_o,
  output logic [15:0]             drop_cnt_o
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Reject configurations the pipeline and lane logic cannot represent.
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("READ_LATENCY must be in 1..4");
  end
  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of 8");
  end

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [ADDR_WIDTH-1:0]   init_ptr_q;
  logic                    init_last;
  logic                    req_ok;
  logic                    wr_req;
  logic                    rd_req;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Stage 0 captures the RAM word at the request edge; the last stage is the output.
  logic [READ_LATENCY-1:0] vld_pipe;
  logic [DATA_WIDTH-1:0]   dat_pipe [READ_LATENCY];

  assign init_last = &init_ptr_q;
  assign req_ok    = bb_ext_en_i && (state_q == ST_READY);
  assign wr_req    = req_ok && (|bb_ext_we_i);
  assign rd_req    = req_ok && !(|bb_ext_we_i);

  assign init_done_o    = (state_q == ST_READY);
  assign bb_ext_valid_o = vld_pipe[READ_LATENCY-1];
  assign bb_ext_dout_o  = dat_pipe[READ_LATENCY-1];

  // Next-state: sweep the whole array once, then serve requests until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  if (init_last) state_d = ST_READY;
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_INIT;
    endcase
  end

  // State register and init pointer; a reset at any point restarts the sweep from 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT) begin
        init_ptr_q <= init_ptr_q + 1'b1;
      end
    end
  end

  // Single write port: init sweep owns it during INIT, byte-lane writes afterwards.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem[init_ptr_q] <= INIT_VALUE;
    end else if (wr_req) begin
      for (int k = 0; k < NB; k++) begin
        if (bb_ext_we_i[k]) begin
          mem[bb_ext_addr_i][8*k +: 8] <= bb_ext_din_i[8*k +: 8];
        end
      end
    end
  end

  // Count requests arriving before the array is ready, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_o <= '0;
    end else if (bb_ext_en_i && (state_q == ST_INIT) && (drop_cnt_o != 16'hFFFF)) begin
      drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end

  // Read pipeline: data stages load only behind a valid beat so the output holds between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        dat_pipe[k] <= '0;
      end
    end else begin
      vld_pipe[0] <= rd_req;
      if (rd_req) begin
        dat_pipe[0] <= mem[bb_ext_addr_i];
      end
      for (int k = 1; k < READ_LATENCY; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        if (vld_pipe[k-1]) begin
          dat_pipe[k] <= dat_pipe[k-1];
        end
      end
    end
  end

endmodule
